opcode_encoder: RTL and testbench

OPCODE_ENCODER -- requirements
Module: opcode_encoder

---
 rtl/opcode_encoder_if.sv | 21 ++
 rtl/opcode_encoder.sv | 57 +++++
 tb/tb_opcode_encoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/opcode_encoder_if.sv
// opcode_encoder_if: instruction request port and encoded byte stream port
interface opcode_encoder_if;
  logic in_valid;
  logic in_ready;
  logic [26:0] in_sel;
  logic [7:0] in_operand;
  logic out_valid;
  logic out_ready;
  logic [7:0] out_byte;
  logic out_last;
  logic err;
  logic [7:0] err_count;
  modport master (
    output in_valid, in_sel, in_operand, out_ready,
    input in_ready, out_valid, out_byte, out_last, err, err_count
  );
  modport slave (
    input in_valid, in_sel, in_operand, out_ready,
    output in_ready, out_valid, out_byte, out_last, err, err_count
  );
endinterface

// File: rtl/opcode_encoder.sv
// opcode_encoder: one-hot instruction class to opcode (+ optional operand) byte stream
module opcode_encoder #(
  parameter bit EMIT_OPERAND = 1'b1
) (
  input logic clk,
  input logic rst_n,
  opcode_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OPC, OPR} state_t;
  state_t state;
  logic [7:0] opr;
  logic [7:0] opc;
  logic sel_ok;
  logic take;
  assign bus.in_ready = state == IDLE || (bus.out_ready && bus.out_last);
  assign take = bus.in_valid && bus.in_ready;
  assign sel_ok = $onehot(bus.in_sel) && ~|bus.in_sel[26:23];
  always_comb begin
    opc = 8'h00;
    for (int k = 0; k < 23; k++)
      if (bus.in_sel[k])
        opc = k < 1  ? 8'h00 :
              k < 5  ? 8'(8'h0F + k) :
              k < 15 ? 8'((k - 3) << 4) :
              k < 17 ? 8'(8'hB1 + k) :
              k < 19 ? 8'((k - 4) << 4) :
                       8'(8'hDD + k);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      opr <= 8'h00;
      bus.out_valid <= 1'b0;
      bus.out_byte <= 8'h00;
      bus.out_last <= 1'b0;
      bus.err <= 1'b0;
      bus.err_count <= 8'h00;
    end else begin
      bus.err <= take && !sel_ok;
      if (take && !sel_ok && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
      if (take && sel_ok) begin
        state <= OPC;
        opr <= bus.in_operand;
        bus.out_valid <= 1'b1;
        bus.out_byte <= opc;
        bus.out_last <= !EMIT_OPERAND;
      end else if (state == OPC && bus.out_ready && EMIT_OPERAND) begin
        state <= OPR;
        bus.out_byte <= opr;
        bus.out_last <= 1'b1;
      end else if (state != IDLE && bus.out_ready) begin
        state <= IDLE;
        bus.out_valid <= 1'b0;
        bus.out_last <= 1'b0;
      end
    end
endmodule

// File: tb/tb_opcode_encoder.sv
// tb_opcode_encoder: directed vectors against a transaction-level byte-queue model
module tb_opcode_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  opcode_encoder_if b1 ();
  opcode_encoder_if b0 ();
  opcode_encoder #(.EMIT_OPERAND(1'b1)) d1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  opcode_encoder #(.EMIT_OPERAND(1'b0)) d0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  logic iv[2];
  logic ordy[2];
  logic [26:0] is[2];
  logic [7:0] io[2];
  logic ir[2];
  logic ov[2];
  logic ol[2];
  logic er[2];
  logic [7:0] ob[2];
  logic [7:0] ec[2];
  assign b1.in_valid = iv[1];
  assign b1.in_sel = is[1];
  assign b1.in_operand = io[1];
  assign b1.out_ready = ordy[1];
  assign b0.in_valid = iv[0];
  assign b0.in_sel = is[0];
  assign b0.in_operand = io[0];
  assign b0.out_ready = ordy[0];
  assign ir[1] = b1.in_ready;
  assign ov[1] = b1.out_valid;
  assign ol[1] = b1.out_last;
  assign er[1] = b1.err;
  assign ob[1] = b1.out_byte;
  assign ec[1] = b1.err_count;
  assign ir[0] = b0.in_ready;
  assign ov[0] = b0.out_valid;
  assign ol[0] = b0.out_last;
  assign er[0] = b0.err;
  assign ob[0] = b0.out_byte;
  assign ec[0] = b0.err_count;
  logic [7:0] ref_map[23] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h30, 8'h40,
                              8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0,
                              8'hC1, 8'hD0, 8'hE0, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int errp = 0;
  int ovc = 0;
  logic [7:0] pb[2][2];
  logic pl[2][2];
  int cnt[2] = '{0, 0};
  logic ee[2] = '{1'b0, 1'b0};
  logic [7:0] ec_e[2] = '{8'h00, 8'h00};
  logic [8:0] lg1[$];
  logic [8:0] lg0[$];
  int lc1[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  // pending bytes of the instruction in flight; pushed on acceptance, popped on transfer
  initial forever begin : model
    int k;
    logic rdy;
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        cnt[i] = 0;
        ee[i] = 1'b0;
        ec_e[i] = 8'h00;
      end else begin
        rdy = cnt[i] == 0 || (ordy[i] && cnt[i] == 1);
        if (cnt[i] > 0 && ordy[i]) begin
          pb[i][0] = pb[i][1];
          pl[i][0] = pl[i][1];
          cnt[i]--;
        end
        ee[i] = 1'b0;
        if (iv[i] && rdy) begin
          if ($countones(is[i]) == 1 && is[i][26:23] == 4'd0) begin
            k = $clog2(is[i]);
            pb[i][cnt[i]] = ref_map[k];
            pl[i][cnt[i]] = i == 0;
            cnt[i]++;
            if (i == 1) begin
              pb[i][cnt[i]] = io[i];
              pl[i][cnt[i]] = 1'b1;
              cnt[i]++;
            end
          end else begin
            ee[i] = 1'b1;
            if (ec_e[i] != 8'hFF) ec_e[i]++;
          end
        end
      end
    end
  end
  // compare every cycle, and log transfers that the next rising edge will complete
  initial forever begin
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_valid%0d", i), 32'(ov[i]), 32'(cnt[i] != 0));
      chk($sformatf("in_ready%0d", i), 32'(ir[i]), 32'(cnt[i] == 0 || (ordy[i] && cnt[i] == 1)));
      chk($sformatf("err%0d", i), 32'(er[i]), 32'(ee[i]));
      chk($sformatf("err_count%0d", i), 32'(ec[i]), 32'(ec_e[i]));
      if (cnt[i] != 0) begin
        chk($sformatf("out_byte%0d", i), 32'(ob[i]), 32'(pb[i][0]));
        chk($sformatf("out_last%0d", i), 32'(ol[i]), 32'(pl[i][0]));
      end
    end
    if (er[1]) errp++;
    if (ov[1]) ovc++;
    if (ov[1] && ordy[1]) begin
      lg1.push_back({ob[1], ol[1]});
      lc1.push_back(cyc);
    end
    if (ov[0] && ordy[0]) lg0.push_back({ob[0], ol[0]});
  end
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input int i, input logic [26:0] sel, input logic [7:0] opd);
    logic acc;
    acc = 1'b0;
    iv[i] = 1'b1;
    is[i] = sel;
    io[i] = opd;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = ir[i];
      @(posedge clk);
      #1;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    iv[i] = 1'b0;
    is[i] = 27'($urandom);
    io[i] = 8'($urandom);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    iv = '{1'b0, 1'b0};
    ordy = '{1'b0, 1'b0};
    is = '{27'd0, 27'd0};
    io = '{8'd0, 8'd0};
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", 32'(ov[1]), 32'd0);
    chk("rst_out_byte", 32'(ob[1]), 32'h00);
    chk("rst_out_last", 32'(ol[1]), 32'd0);
    chk("rst_err", 32'(er[1]), 32'd0);
    chk("rst_err_count", 32'(ec[1]), 32'd0);
    chk("rst_in_ready", 32'(ir[1]), 32'd1);
    idle(2);
    rst_n = 1'b1;
    ordy[1] = 1'b1;
    lg1.delete();
    for (int k = 0; k < 23; k++) send(1, 27'(1) << k, 8'(k) ^ 8'h5A);
    idle(3);
    chk("sweep_count", 32'(lg1.size()), 32'd46);
    chk("sweep_k0", 32'(lg1[0]), 32'({8'h00, 1'b0}));
    chk("sweep_k7", 32'(lg1[14]), 32'({8'h40, 1'b0}));
    chk("sweep_k16", 32'(lg1[32]), 32'({8'hC1, 1'b0}));
    chk("sweep_k22", 32'(lg1[44]), 32'({8'hF3, 1'b0}));
    chk("sweep_k22_opr", 32'(lg1[45]), 32'({8'h4C, 1'b1}));
    errp = 0;
    ovc = 0;
    send(1, 27'h3, 8'h01);
    send(1, 27'(1) << 24, 8'h02);
    idle(3);
    chk("inv_err_pulses", 32'(errp), 32'd2);
    chk("inv_out_valid_cycles", 32'(ovc), 32'd0);
    chk("inv_err_count", 32'(ec[1]), 32'd2);
    ordy[1] = 1'b0;
    lg1.delete();
    send(1, 27'(1) << 9, 8'hA5);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stall_byte", 32'(ob[1]), 32'h60);
      chk("stall_last", 32'(ol[1]), 32'd0);
    end
    @(posedge clk);
    #1 ordy[1] = 1'b1;
    idle(4);
    chk("stall_count", 32'(lg1.size()), 32'd2);
    chk("stall_opc", 32'(lg1[0]), 32'({8'h60, 1'b0}));
    chk("stall_opr", 32'(lg1[1]), 32'({8'hA5, 1'b1}));
    lg1.delete();
    lc1.delete();
    send(1, 27'(1) << 1, 8'h3B);
    send(1, 27'(1) << 20, 8'hC4);
    idle(4);
    chk("b2b_count", 32'(lg1.size()), 32'd4);
    chk("b2b_0", 32'(lg1[0]), 32'({8'h10, 1'b0}));
    chk("b2b_1", 32'(lg1[1]), 32'({8'h3B, 1'b1}));
    chk("b2b_2", 32'(lg1[2]), 32'({8'hF1, 1'b0}));
    chk("b2b_3", 32'(lg1[3]), 32'({8'hC4, 1'b1}));
    chk("b2b_span", 32'(lc1[3] - lc1[0]), 32'd3);
    ordy[0] = 1'b1;
    send(0, 27'(1) << 0, 8'h99);
    send(0, 27'(1) << 5, 8'h98);
    send(0, 27'(1) << 18, 8'h97);
    idle(3);
    chk("e0_count", 32'(lg0.size()), 32'd3);
    chk("e0_k0", 32'(lg0[0]), 32'({8'h00, 1'b1}));
    chk("e0_k5", 32'(lg0[1]), 32'({8'h20, 1'b1}));
    chk("e0_k18", 32'(lg0[2]), 32'({8'hE0, 1'b1}));
    ordy[1] = 1'b0;
    send(1, 27'(1) << 3, 8'h77);
    ordy[1] = 1'b1;
    @(posedge clk);
    #1 ordy[1] = 1'b0;
    @(negedge clk);
    chk("opr_byte", 32'(ob[1]), 32'h77);
    chk("opr_last", 32'(ol[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov[1]), 32'd0);
    chk("mid_rst_err_count", 32'(ec[1]), 32'd0);
    chk("mid_rst_out_byte", 32'(ob[1]), 32'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    ordy[1] = 1'b1;
    lg1.delete();
    send(1, 27'(1) << 12, 8'h3C);
    idle(3);
    chk("post_rst_opc", 32'(lg1[0]), 32'({8'h90, 1'b0}));
    chk("post_rst_opr", 32'(lg1[1]), 32'({8'h3C, 1'b1}));
    for (int n = 0; n < 300; n++)
      send(1, n % 3 == 0 ? 27'd0 : n % 3 == 1 ? 27'h5 : 27'(1) << (23 + n % 4), 8'(n));
    idle(2);
    chk("sat_err_count", 32'(ec[1]), 32'hFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
